// File: rtl/test_access_ctrl_if.sv
// Bus bundle between the TX/RX datapath, the test pins and the test-access controller.
// The slave modport is the controller's view; master is the datapath/pin side.
interface test_access_ctrl_if #(
    parameter int NUM_SRC = 8,
    parameter int SRC_W   = 4,
    parameter int NUM_OUT = 2,
    parameter int NUM_CTL = 8
);
    logic                       inCfgData;
    logic                       inCfgShift;
    logic                       inCfgUpdate;
    logic                       outCfgData;
    logic [NUM_SRC*SRC_W-1:0]   inSrc;
    logic                       inTrigger;
    logic [NUM_OUT*SRC_W-1:0]   outObs;
    logic [NUM_CTL-1:0]         inCtlFunc;
    logic [NUM_CTL-1:0]         outCtl;
    logic [7:0]                 outCaptureCount;

    modport slave (
        input  inCfgData, inCfgShift, inCfgUpdate, inSrc, inTrigger, inCtlFunc,
        output outCfgData, outObs, outCtl, outCaptureCount
    );

    modport master (
        output inCfgData, inCfgShift, inCfgUpdate, inSrc, inTrigger, inCtlFunc,
        input  outCfgData, outObs, outCtl, outCaptureCount
    );
endinterface

// File: rtl/test_access_ctrl.sv
// Programmable test-access controller: serial config chain with shadow update,
// selectable live/captured observation ports and per-bit control overrides.
module test_access_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int SRC_W   = 4,
    parameter int NUM_OUT = 2,
    parameter int NUM_CTL = 8
) (
    input  logic                    inClock,
    input  logic                    inReset,
    test_access_ctrl_if.slave       bus
);
    localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CFG_L  = NUM_OUT*(SEL_W+1) + 2*NUM_CTL;
    localparam int MODE_B = NUM_OUT*SEL_W;
    localparam int OEN_B  = NUM_OUT*(SEL_W+1);
    localparam int OVAL_B = OEN_B + NUM_CTL;

    logic [CFG_L-1:0]           chain;
    logic [CFG_L-1:0]           active;
    logic [SRC_W-1:0]           cap  [NUM_OUT];
    logic [SRC_W-1:0]           live [NUM_OUT];
    logic [NUM_OUT*SRC_W-1:0]   obs;
    logic                       trig_q;
    logic [7:0]                 cap_count;
    logic                       trig_evt;

    assign trig_evt = bus.inTrigger && !trig_q;

    // Out-of-range selections resolve to zero because no source index matches.
    always_comb begin
        for (int j = 0; j < NUM_OUT; j++) begin
            live[j] = '0;
            for (int k = 0; k < NUM_SRC; k++) begin
                if (active[j*SEL_W +: SEL_W] == SEL_W'(k)) begin
                    live[j] = bus.inSrc[k*SRC_W +: SRC_W];
                end
            end
        end
    end

    always_ff @(posedge inClock) begin
        if (inReset) begin
            chain     <= '0;
            active    <= '0;
            trig_q    <= 1'b0;
            cap_count <= '0;
            obs       <= '0;
            for (int j = 0; j < NUM_OUT; j++) begin
                cap[j] <= '0;
            end
        end else begin
            if (bus.inCfgShift) begin
                chain <= {bus.inCfgData, chain[CFG_L-1:1]};
            end
            // Update takes the pre-edge chain, so a coincident final shift is not included.
            if (bus.inCfgUpdate) begin
                active <= chain;
            end
            trig_q <= bus.inTrigger;
            if (trig_evt) begin
                for (int j = 0; j < NUM_OUT; j++) begin
                    cap[j] <= live[j];
                end
                if (cap_count != 8'hFF) begin
                    cap_count <= cap_count + 8'd1;
                end
            end
            for (int j = 0; j < NUM_OUT; j++) begin
                obs[j*SRC_W +: SRC_W] <= active[MODE_B + j] ? cap[j] : live[j];
            end
        end
    end

    assign bus.outCfgData      = chain[0];
    assign bus.outObs          = obs;
    assign bus.outCaptureCount = cap_count;

    always_comb begin
        for (int i = 0; i < NUM_CTL; i++) begin
            bus.outCtl[i] = active[OEN_B + i] ? active[OVAL_B + i] : bus.inCtlFunc[i];
        end
    end
endmodule

// File: tb/tb_test_access_ctrl.sv
// Directed self-checking bench for test_access_ctrl at default parameters.
module tb_test_access_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    test_access_ctrl_if #(.NUM_SRC(8), .SRC_W(4), .NUM_OUT(2), .NUM_CTL(8)) bus ();

    test_access_ctrl #(.NUM_SRC(8), .SRC_W(4), .NUM_OUT(2), .NUM_CTL(8)) dut (
        .inClock (clk),
        .inReset (rst),
        .bus     (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic set_src(input int k, input logic [3:0] v);
        bus.inSrc[k*4 +: 4] = v;
    endtask

    // LSB first: after 24 shifts w[0] sits at chain bit 0.
    task automatic shift_word(input logic [23:0] w);
        for (int i = 0; i < 24; i++) begin
            bus.inCfgData  = w[i];
            bus.inCfgShift = 1'b1;
            tick();
        end
        bus.inCfgShift = 1'b0;
        bus.inCfgData  = 1'b0;
    endtask

    task automatic update();
        bus.inCfgUpdate = 1'b1;
        tick();
        bus.inCfgUpdate = 1'b0;
    endtask

    logic [23:0] pat;
    logic [23:0] q;

    initial begin
        bus.inCfgData   = 1'b0;
        bus.inCfgShift  = 1'b0;
        bus.inCfgUpdate = 1'b0;
        bus.inSrc       = '0;
        bus.inTrigger   = 1'b0;
        bus.inCtlFunc   = 8'hA5;

        // reset
        tick();
        tick();
        check("rst_obs", 32'(bus.outObs), 32'h0);
        check("rst_count", 32'(bus.outCaptureCount), 32'h0);
        check("rst_ctl", 32'(bus.outCtl), 32'hA5);
        check("rst_cfgdata", 32'(bus.outCfgData), 32'h0);
        rst = 1'b0;
        tick();

        // live select: sel0=3, sel1=5
        set_src(3, 4'h9);
        set_src(5, 4'h6);
        shift_word(24'h00002B);
        check("shift_bit0", 32'(bus.outCfgData), 32'h1);
        check("pre_update_obs", 32'(bus.outObs), 32'h0);
        update();
        tick();
        check("live_obs", 32'(bus.outObs), 32'h69);
        set_src(3, 4'hA);
        #1;
        check("live_latency_hold", 32'(bus.outObs), 32'h69);
        tick();
        check("live_latency_new", 32'(bus.outObs), 32'h6A);

        // override: ovr_en=0F ovr_val=05
        bus.inCtlFunc = 8'hF0;
        #1;
        check("ctl_functional", 32'(bus.outCtl), 32'hF0);
        shift_word(24'h050F2B);
        check("ctl_before_update", 32'(bus.outCtl), 32'hF0);
        update();
        check("ctl_override", 32'(bus.outCtl), 32'hF5);

        // capture/hold: sel0=2 mode0=1, sel1=0 live
        set_src(2, 4'h3);
        set_src(0, 4'h0);
        shift_word(24'h000042);
        update();
        tick();
        check("count_before_trig", 32'(bus.outCaptureCount), 32'h0);
        bus.inTrigger = 1'b1;
        tick();
        check("count_one", 32'(bus.outCaptureCount), 32'h1);
        bus.inTrigger = 1'b0;
        set_src(2, 4'hC);
        tick();
        check("cap_hold", 32'(bus.outObs[3:0]), 32'h3);
        tick();
        tick();
        check("cap_hold_later", 32'(bus.outObs[3:0]), 32'h3);
        check("count_still_one", 32'(bus.outCaptureCount), 32'h1);

        // held trigger: one capture only
        bus.inTrigger = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("held_trig_count", 32'(bus.outCaptureCount), 32'h2);
        check("held_trig_cap", 32'(bus.outObs[3:0]), 32'hC);
        bus.inTrigger = 1'b0;
        tick();

        // saturation: 2 + 253 = 255, then more pulses
        for (int i = 0; i < 252; i++) begin
            bus.inTrigger = 1'b1; tick();
            bus.inTrigger = 1'b0; tick();
        end
        check("count_254", 32'(bus.outCaptureCount), 32'd254);
        bus.inTrigger = 1'b1; tick();
        bus.inTrigger = 1'b0; tick();
        check("count_255", 32'(bus.outCaptureCount), 32'd255);
        for (int i = 0; i < 47; i++) begin
            bus.inTrigger = 1'b1; tick();
            bus.inTrigger = 1'b0; tick();
        end
        check("count_saturated", 32'(bus.outCaptureCount), 32'd255);

        // trigger with update: capture uses pre-update sel0=2
        set_src(2, 4'h5);
        set_src(4, 4'h7);
        shift_word(24'h000044);
        bus.inTrigger   = 1'b1;
        bus.inCfgUpdate = 1'b1;
        tick();
        bus.inTrigger   = 1'b0;
        bus.inCfgUpdate = 1'b0;
        tick();
        check("trig_update_cap", 32'(bus.outObs[3:0]), 32'h5);

        // readback
        pat = 24'hC3A51E;
        shift_word(pat);
        for (int i = 0; i < 24; i++) begin
            check($sformatf("readback_%0d", i), 32'(bus.outCfgData), 32'(pat[i]));
            bus.inCfgData  = 1'b0;
            bus.inCfgShift = 1'b1;
            tick();
        end
        bus.inCfgShift = 1'b0;
        check("readback_empty", 32'(bus.outCfgData), 32'h0);

        // update coincident with final shift: active = {q[22:0], 0} = 3CFF00
        q = 24'h9E7F80;
        for (int i = 0; i < 24; i++) begin
            bus.inCfgData   = q[i];
            bus.inCfgShift  = 1'b1;
            bus.inCfgUpdate = (i == 23);
            tick();
        end
        bus.inCfgShift  = 1'b0;
        bus.inCfgUpdate = 1'b0;
        check("simul_pre_shift", 32'(bus.outCtl), 32'h3C);
        update();
        check("simul_shift_done", 32'(bus.outCtl), 32'h9E);

        // reset mid-load
        set_src(0, 4'h0);
        set_src(1, 4'hB);
        for (int i = 0; i < 12; i++) begin
            bus.inCfgData  = 1'b1;
            bus.inCfgShift = 1'b1;
            tick();
        end
        bus.inCfgShift = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_cfgdata", 32'(bus.outCfgData), 32'h0);
        check("midrst_count", 32'(bus.outCaptureCount), 32'h0);
        update();
        check("midrst_ctl", 32'(bus.outCtl), 32'hF0);
        tick();
        check("midrst_obs", 32'(bus.outObs), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
